// File: rtl/onchip_mem_byte_streamer_if.sv
// Bus bundle for the byte streamer: the RAM read port and the
// valid/ready byte stream to the serial transmitter.
// The master side is the streamer; the slave side is the RAM plus transmitter.
interface onchip_mem_byte_streamer_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [31:0]       mem_readdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  mem_readdata,
        output tx_data, tx_valid,
        input  tx_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output mem_readdata,
        input  tx_data, tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/onchip_mem_byte_streamer.sv
// Read-side DMA stage: fetches a run of 32-bit words from on-chip RAM and
// streams them out LSB-first as bytes over a valid/ready interface.
// Every word costs one READ cycle (address out) and one CAPT cycle (data in)
// before its bytes can be sent back-to-back.
module onchip_mem_byte_streamer #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  byte_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    onchip_mem_byte_streamer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_cs_q, mem_cs_d;

    // Next-state and next-output logic; abort overrides everything outside IDLE
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        idx_d         = idx_q;
        word_d        = word_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        mem_address_d = mem_address_q;
        mem_cs_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    busy_d = 1'b1;
                    if (byte_count != '0) begin
                        addr_d        = start_addr;
                        rem_d         = byte_count;
                        mem_address_d = start_addr;
                        mem_cs_d      = 1'b1;
                        state_d       = S_READ;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                word_d     = bus.mem_readdata;
                idx_d      = 2'd0;
                tx_data_d  = bus.mem_readdata[7:0];
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (tx_valid_q && bus.tx_ready) begin
                    rem_d = rem_q - 1'b1;
                    idx_d = idx_q + 2'd1;
                    if (rem_q == LEN_W'(1)) begin
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_DONE;
                    end else if (idx_q == 2'd3) begin
                        tx_valid_d    = 1'b0;
                        addr_d        = addr_q + 1'b1;
                        mem_address_d = addr_q + 1'b1;
                        mem_cs_d      = 1'b1;
                        state_d       = S_READ;
                    end else begin
                        tx_data_d = word_q[{idx_d, 3'b000} +: 8];
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                tx_valid_d = 1'b0;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            mem_cs_d   = 1'b0;
        end
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            rem_q         <= '0;
            idx_q         <= 2'd0;
            word_q        <= 32'h0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_address_q <= '0;
            mem_cs_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            idx_q         <= idx_d;
            word_q        <= word_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_address_q <= mem_address_d;
            mem_cs_q      <= mem_cs_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_chipselect = mem_cs_q;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;
    assign bus.tx_data        = tx_data_q;
    assign bus.tx_valid       = tx_valid_q;

endmodule

// File: tb/tb_onchip_mem_byte_streamer.sv
// Testbench for onchip_mem_byte_streamer: a RAM model answers reads one
// cycle after the address, and a reference model derives the expected byte
// stream and word-address sequence straight from (start_addr, byte_count).
module tb_onchip_mem_byte_streamer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [10:0] start_addr;
    logic [12:0] byte_count;
    logic        abort;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    logic [31:0] ram [0:2047];

    onchip_mem_byte_streamer_if #(.ADDR_W(11)) bus ();

    onchip_mem_byte_streamer #(.ADDR_W(11), .LEN_W(13)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .byte_count (byte_count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: data appears one cycle after a selected address
    always @(posedge clk) begin
        if (bus.mem_chipselect)
            bus.mem_readdata <= ram[bus.mem_address];
    end

    // Single comparison point: counts every check, reports any miscompare
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Issue a one-cycle start command; called and returns on a falling edge
    task automatic applyStimulus(input logic [10:0] addr, input logic [12:0] count);
        start      = 1'b1;
        start_addr = addr;
        byte_count = count;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Run one transfer against the reference model.
    // readyMode: 0 always ready, 1 pattern 1,0,0, 2 random.
    // killMode: 0 none, 1 abort, 2 reset; applied once killAfter bytes are accepted.
    task automatic runTransfer(input logic [10:0] addr, input int count, input int readyMode,
                               input int killMode, input int killAfter);
        logic [7:0]  expBytes[$];
        logic [10:0] expAddr[$];
        int   accepted  = 0;
        int   cycle     = 0;
        int   lastAcc   = 0;
        int   doneSeen  = 0;
        int   killPhase = 0;
        bit   afterDone = 0;
        bit   finished  = 0;
        bit   prevValid = 0;
        bit   prevReady = 0;
        bit   rdy;
        logic [7:0] prevData = 8'h00;

        for (int i = 0; i < count; i++) begin
            logic [31:0] w;
            w = ram[(int'(addr) + i / 4) % 2048];
            expBytes.push_back(w[8 * (i % 4) +: 8]);
        end
        for (int k = 0; k < (count + 3) / 4; k++)
            expAddr.push_back(11'((int'(addr) + k) % 2048));

        applyStimulus(addr, 13'(count));

        while (!finished && cycle < 20 * count + 60) begin
            cycle++;
            if (killPhase == 1) begin
                checkOutput("kill_valid", 32'(bus.tx_valid), 32'd0);
                checkOutput("kill_busy", 32'(busy), 32'd0);
                checkOutput("kill_done", 32'(done), 32'd0);
                checkOutput("kill_cs", 32'(bus.mem_chipselect), 32'd0);
                if (killMode == 2) begin
                    checkOutput("rst_txdata", 32'(bus.tx_data), 32'd0);
                    checkOutput("rst_addr", 32'(bus.mem_address), 32'd0);
                end
                abort     = 1'b0;
                reset_n   = 1'b1;
                bus.tx_ready = 1'b0;
                killPhase = 2;
            end else if (killPhase == 2) begin
                checkOutput("kill_nodone", 32'(done), 32'd0);
                checkOutput("kill_idle_valid", 32'(bus.tx_valid), 32'd0);
                finished = 1;
            end else if (afterDone) begin
                checkOutput("busy_after", 32'(busy), 32'd0);
                checkOutput("done_width", 32'(done), 32'd0);
                finished = 1;
            end else begin
                if (cycle == 1)
                    checkOutput("busy_start", 32'(busy), 32'd1);
                if (count == 0)
                    checkOutput("c0_valid", 32'(bus.tx_valid), 32'd0);
                if (bus.mem_chipselect) begin
                    if (expAddr.size() == 0)
                        checkOutput("extra_read", 32'd1, 32'd0);
                    else
                        checkOutput("rd_addr", 32'(bus.mem_address), 32'(expAddr.pop_front()));
                end
                if (prevValid && !prevReady) begin
                    checkOutput("hold_valid", 32'(bus.tx_valid), 32'd1);
                    checkOutput("hold_data", 32'(bus.tx_data), 32'(prevData));
                end
                if (done) begin
                    checkOutput("done_time", 32'(cycle), (count == 0) ? 32'd1 : 32'(lastAcc + 1));
                    checkOutput("done_busy", 32'(busy), 32'd1);
                    doneSeen++;
                    afterDone = 1;
                end

                case (readyMode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cycle % 3) == 0;
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                bus.tx_ready = rdy;

                if (killMode != 0 && accepted == killAfter && bus.tx_valid) begin
                    if (killMode == 1) abort = 1'b1;
                    else               reset_n = 1'b0;
                    killPhase = 1;
                end

                if (bus.tx_valid && rdy) begin
                    if (accepted < count)
                        checkOutput("byte", 32'(bus.tx_data), 32'(expBytes[accepted]));
                    else
                        checkOutput("extra_byte", 32'd1, 32'd0);
                    if (readyMode == 0)
                        checkOutput("byte_time", 32'(cycle), 32'(3 + accepted + 2 * (accepted / 4)));
                    accepted++;
                    lastAcc = cycle;
                end
                prevValid = bus.tx_valid;
                prevReady = rdy;
                prevData  = bus.tx_data;
            end
            @(negedge clk);
        end

        if (!finished)
            checkOutput("timeout", 32'd1, 32'd0);
        if (killMode == 0) begin
            checkOutput("byte_cnt", 32'(accepted), 32'(count));
            checkOutput("done_cnt", 32'(doneSeen), 32'd1);
            checkOutput("reads_left", 32'(expAddr.size()), 32'd0);
        end
        bus.tx_ready = 1'b0;
        abort        = 1'b0;
        reset_n      = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        start_addr   = '0;
        byte_count   = '0;
        abort        = 1'b0;
        bus.tx_ready = 1'b0;

        for (int i = 0; i < 2048; i++)
            ram[i] = $urandom;
        ram[16] = 32'h44332211;
        ram[5]  = 32'hDDCCBBAA;
        ram[6]  = 32'h00EE9988;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("rst_data", 32'(bus.tx_data), 32'd0);
        checkOutput("rst_addr", 32'(bus.mem_address), 32'd0);
        checkOutput("rst_cs", 32'(bus.mem_chipselect), 32'd0);
        checkOutput("tie_write", 32'(bus.mem_write), 32'd0);
        checkOutput("tie_be", 32'(bus.mem_byteenable), 32'hF);
        checkOutput("tie_clken", 32'(bus.mem_clken), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed transfers");
        runTransfer(11'h010, 4, 0, 0, 0);
        runTransfer(11'd5, 6, 0, 0, 0);
        runTransfer(11'h010, 4, 1, 0, 0);
        runTransfer(11'd2047, 8, 0, 0, 0);
        runTransfer(11'd0, 0, 0, 0, 0);
        runTransfer(11'd100, 12, 0, 1, 2);
        runTransfer(11'd100, 12, 0, 0, 0);
        runTransfer(11'd200, 12, 0, 2, 2);
        runTransfer(11'd200, 12, 2, 0, 0);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 12; n++) begin
            logic [10:0] a;
            int          c;
            a = (n % 3 == 0) ? 11'(2040 + $urandom_range(0, 7)) : 11'($urandom_range(0, 2047));
            c = int'($urandom_range(1, 40));
            runTransfer(a, c, int'($urandom_range(0, 2)), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
